// File: rtl/blood_anim_ctrl_pkg.sv
// Shared definitions for the blood splatter animation controller:
// sprite geometry, the transparent colour key and the FSM state encoding.
package blood_anim_ctrl_pkg;

   localparam int          SPRITE_SIZE = 64;
   localparam logic [11:0] TRANSPARENT = 12'h000;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PLAY = 1'b1
   } state_e;

endpackage

// File: rtl/blood_anim_ctrl_if.sv
// Sprite ROM bus between the animation controller and the frame-selected
// 64x64 sprite ROM.
//   rom_frame : sprite frame select  (controller -> ROM)
//   rom_row   : row within sprite    (controller -> ROM)
//   rom_col   : column within sprite (controller -> ROM)
//   rom_data  : 12-bit colour, valid one clk after the address (ROM -> controller)
interface blood_anim_ctrl_if;
   logic [3:0]  rom_frame;
   logic [5:0]  rom_row;
   logic [5:0]  rom_col;
   logic [11:0] rom_data;

   modport master (output rom_frame, rom_row, rom_col, input rom_data);
   modport slave  (input rom_frame, rom_row, rom_col, output rom_data);
endinterface

// File: rtl/blood_pixel_window.sv
// Per-pixel sprite window: decides whether the current pixel lies inside the
// displayed 64x64 sprite box, produces the sprite-relative ROM row/column,
// and delays the in-box flag by one clk to line up with the ROM data.
//   clk, reset          : clock, synchronous active-high reset
//   disp_active         : a sprite is being displayed this video frame
//   disp_x, disp_y      : displayed sprite top-left
//   x, y, video_on      : current pixel coordinate and active-video flag
//   rom_row, rom_col    : sprite-relative address (combinational)
//   in_box_d            : in-box flag, registered once
module blood_pixel_window
   import blood_anim_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       disp_active,
   input  logic [9:0] disp_x,
   input  logic [9:0] disp_y,
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic       video_on,
   output logic [5:0] rom_row,
   output logic [5:0] rom_col,
   output logic       in_box_d
);

   logic [10:0] x_end;
   logic [10:0] y_end;
   logic [9:0]  x_off;
   logic [9:0]  y_off;
   logic        in_box;

   // 11-bit ends so a sprite near 1023 does not wrap back to column 0.
   assign x_end = {1'b0, disp_x} + 11'(SPRITE_SIZE);
   assign y_end = {1'b0, disp_y} + 11'(SPRITE_SIZE);

   assign in_box = disp_active && video_on
                   && (x >= disp_x) && ({1'b0, x} < x_end)
                   && (y >= disp_y) && ({1'b0, y} < y_end);

   assign x_off   = x - disp_x;
   assign y_off   = y - disp_y;
   assign rom_col = x_off[5:0];
   assign rom_row = y_off[5:0];

   always_ff @(posedge clk) begin
      if (reset) in_box_d <= 1'b0;
      else       in_box_d <= in_box;
   end

endmodule

// File: rtl/blood_anim_ctrl.sv
// Blood splatter animation controller. A hit starts (or restarts) a
// NUM_FRAMES-frame sprite animation at the given origin, advancing one sprite
// frame every TICKS_PER_FRAME video frames. Display registers are only
// reloaded at vblank so a sprite never tears mid-frame.
//   clk, reset          : clock, synchronous active-high reset
//   frame_tick          : one-cycle pulse at vblank start
//   hit, hit_x, hit_y   : effect request and sprite top-left
//   x, y, video_on      : current pixel coordinate and active-video flag
//   rom                 : sprite ROM bus (master side)
//   blood_on, blood_rgb : sprite pixel valid / colour, one clk after x/y
//   busy                : animation in progress
//
// state   | meaning
// IDLE    | no effect running
// PLAY    | animation advancing on frame_tick
module blood_anim_ctrl
   import blood_anim_ctrl_pkg::*;
#(
   parameter int NUM_FRAMES      = 15,
   parameter int TICKS_PER_FRAME = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     frame_tick,
   input  logic                     hit,
   input  logic [9:0]               hit_x,
   input  logic [9:0]               hit_y,
   input  logic [9:0]               x,
   input  logic [9:0]               y,
   input  logic                     video_on,
   blood_anim_ctrl_if.master        rom,
   output logic                     blood_on,
   output logic [11:0]              blood_rgb,
   output logic                     busy
);

   state_e     state_q, state_d;
   logic [3:0] frame_idx_q, frame_idx_d;
   logic [3:0] tick_cnt_q, tick_cnt_d;
   logic [9:0] org_x_q, org_x_d;
   logic [9:0] org_y_q, org_y_d;

   logic       disp_active_q;
   logic [3:0] disp_frame_q;
   logic [9:0] disp_x_q;
   logic [9:0] disp_y_q;

   logic       in_box_d;
   logic [5:0] win_row;
   logic [5:0] win_col;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         frame_idx_q   <= '0;
         tick_cnt_q    <= '0;
         org_x_q       <= '0;
         org_y_q       <= '0;
         disp_active_q <= 1'b0;
         disp_frame_q  <= '0;
         disp_x_q      <= '0;
         disp_y_q      <= '0;
      end else begin
         state_q     <= state_d;
         frame_idx_q <= frame_idx_d;
         tick_cnt_q  <= tick_cnt_d;
         org_x_q     <= org_x_d;
         org_y_q     <= org_y_d;
         // Snapshot the post-update values so the new frame shows this vblank.
         if (frame_tick) begin
            disp_active_q <= (state_d == ST_PLAY);
            disp_frame_q  <= frame_idx_d;
            disp_x_q      <= org_x_d;
            disp_y_q      <= org_y_d;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      frame_idx_d = frame_idx_q;
      tick_cnt_d  = tick_cnt_q;
      org_x_d     = org_x_q;
      org_y_d     = org_y_q;
      if (hit) begin
         // A hit always wins over a simultaneous frame_tick.
         state_d     = ST_PLAY;
         frame_idx_d = '0;
         tick_cnt_d  = '0;
         org_x_d     = hit_x;
         org_y_d     = hit_y;
      end else if (state_q == ST_PLAY && frame_tick) begin
         if (tick_cnt_q == 4'(TICKS_PER_FRAME - 1)) begin
            tick_cnt_d = '0;
            if (frame_idx_q == 4'(NUM_FRAMES - 1)) begin
               state_d     = ST_IDLE;
               frame_idx_d = '0;
            end else begin
               frame_idx_d = frame_idx_q + 4'd1;
            end
         end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
         end
      end
   end

   always_comb begin
      busy      = (state_q == ST_PLAY);
      blood_on  = in_box_d && (rom.rom_data != TRANSPARENT);
      blood_rgb = (in_box_d && (rom.rom_data != TRANSPARENT)) ? rom.rom_data : TRANSPARENT;
   end

   blood_pixel_window u_window (
      .clk         (clk),
      .reset       (reset),
      .disp_active (disp_active_q),
      .disp_x      (disp_x_q),
      .disp_y      (disp_y_q),
      .x           (x),
      .y           (y),
      .video_on    (video_on),
      .rom_row     (win_row),
      .rom_col     (win_col),
      .in_box_d    (in_box_d)
   );

   assign rom.rom_frame = disp_frame_q;
   assign rom.rom_row   = win_row;
   assign rom.rom_col   = win_col;

endmodule

// File: doc/blood_anim_ctrl.md
BLOOD_ANIM_CTRL -- requirements
Module: blood_anim_ctrl

Interface
REQ-001 SHALL have parameter NUM_FRAMES, default 15, number of blood sprite frames (1..16).
REQ-002 SHALL have parameter TICKS_PER_FRAME, default 4, video frames each sprite frame is shown (1..15).
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  input  1  system/pixel clock; reset  input  1  synchronous active-high reset.
REQ-004 SHALL have port frame_tick  input  1  one-cycle pulse once per video frame, at vblank start.
REQ-005 SHALL have port hit  input  1  one-cycle pulse requesting a blood effect.
REQ-006 SHALL have ports hit_x / hit_y  input  10 each  sprite top-left for the requested effect, sampled with hit.
REQ-007 SHALL have ports x / y  input  10 each  current pixel coordinate; video_on  input  1  active-video flag.
REQ-008 SHALL have ports rom_frame  output  4, rom_row  output  6, rom_col  output  6  address to the frame-selected 64x64 sprite ROM.
REQ-009 SHALL have port rom_data  input  12  ROM colour, valid one clk after the address.
REQ-010 SHALL have ports blood_on  output  1, blood_rgb  output  12, busy  output  1.

Function
REQ-011 SHALL implement FSM IDLE / PLAY; IDLE -> PLAY on hit; PLAY -> IDLE on the advance out of frame NUM_FRAMES-1.
REQ-012 On hit (any state) SHALL latch hit_x/hit_y into working origin, clear frame_idx and tick_cnt to 0, and enter PLAY; hit in PLAY restarts the effect.
REQ-013 In PLAY, on frame_tick without hit: if tick_cnt == TICKS_PER_FRAME-1, clear tick_cnt and increment frame_idx, else increment tick_cnt.
REQ-014 If frame_idx == NUM_FRAMES-1 when it would increment, SHALL go to IDLE with frame_idx held at 0.
REQ-015 hit and frame_tick in the same cycle: hit wins; that frame_tick does not advance tick_cnt.
REQ-016 busy SHALL equal (state == PLAY).
REQ-017 Display registers disp_active, disp_frame, disp_x, disp_y SHALL load from state==PLAY, frame_idx and working origin only on frame_tick, after the REQ-012..015 update, so no frame tears.
REQ-018 in_box SHALL equal disp_active && video_on && x>=disp_x && x<disp_x+64 && y>=disp_y && y<disp_y+64, using 11-bit sums (no wrap at 1023).
REQ-019 rom_row = (y-disp_y)[5:0], rom_col = (x-disp_x)[5:0], rom_frame = disp_frame; combinational from x/y.
REQ-020 in_box SHALL be registered once (in_box_d) to align with rom_data.
REQ-021 blood_on SHALL equal in_box_d && (rom_data != 12'h000); colour 000 is transparent.
REQ-022 blood_rgb SHALL equal rom_data when blood_on, else 12'h000.
REQ-023 Pixel latency: x/y at cycle t -> blood_on/blood_rgb at t+1.

Reset
REQ-024 reset SHALL force state IDLE, frame_idx 0, tick_cnt 0, origin 0, all display registers 0, in_box_d 0.
REQ-025 After reset: busy 0, blood_on 0, blood_rgb 0, rom_frame 0.
REQ-026 reset mid-PLAY SHALL abort the effect; the next frame_tick shows nothing.

Structure
REQ-027 Shared package SHALL hold SPRITE_SIZE=64, TRANSPARENT=12'h000, and the state encoding.
REQ-028 Bounding-box compare, offset subtract and in_box_d SHALL be sub-module blood_pixel_window; the FSM and display registers remain in blood_anim_ctrl.

Verification
REQ-029 hit with hit_x=100, hit_y=50, then frame_tick -> x=100,y=50 gives rom_row=0, rom_col=0, rom_frame=0; x=163,y=113 in box; x=164 or y=114 not in box.
REQ-030 Defaults, single hit, 60 frame_ticks -> rom_frame steps every 4 ticks 0..14; busy drops on the 60th tick; disp_active is 0 after it.
REQ-031 hit at origin (80,80) during frame 7, then frame_tick -> frame 0 at origin (80,80); hit+frame_tick same cycle -> tick_cnt stays 0.
REQ-032 rom_data=12'h000 with in_box_d=1 -> blood_on 0, blood_rgb 0; rom_data=12'hE00 -> blood_on 1, blood_rgb 12'hE00, one cycle after address.
REQ-033 hit_x=1000, x=1023 -> in_box 1, rom_col=23; x=0 -> in_box 0 (no wrap).
REQ-034 reset during PLAY frame 5 -> busy 0 next cycle; next frame_tick shows no sprite.
